// File: rtl/ftoi_pipe.sv
// Two-stage float32 -> signed INT_W converter with valid/ready flow control and saturation.
// Define FTOI_STATUS_EN to add the out_ovf / out_inexact status ports.
module ftoi_pipe #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_rmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data
`ifdef FTOI_STATUS_EN
    ,
    output logic             out_ovf,
    output logic             out_inexact
`endif
);

    localparam int FW = INT_W + 25;
    localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic adv;

    // ---------------- stage 1: decode and align ----------------
    logic [7:0]        in_exp;
    logic              in_mant_nz;
    logic signed [31:0] dec_e;
    logic [6:0]        dec_sh;
    logic [FW-1:0]     dec_fixed;

    logic             s1_valid_q;
    logic             s1_sign_q,   s1_sign_d;
    logic [INT_W-1:0] s1_int_q,    s1_int_d;
    logic             s1_guard_q,  s1_guard_d;
    logic             s1_sticky_q, s1_sticky_d;
    logic             s1_big_q,    s1_big_d;
    logic             s1_nan_q,    s1_nan_d;
    logic [1:0]       s1_rmode_q;

    assign in_exp     = in_data[30:23];
    assign in_mant_nz = |in_data[22:0];
    assign dec_e      = $signed({24'd0, in_exp}) - 32'sd127;
    assign dec_sh     = 7'(dec_e + 32'sd2);
    // Fixed point with 25 fraction bits: bit 24 is the guard, bits 23:0 feed sticky.
    assign dec_fixed  = {{(INT_W+1){1'b0}}, 1'b1, in_data[22:0]} << dec_sh;

    always_comb begin
        s1_sign_d   = in_data[31];
        s1_int_d    = '0;
        s1_guard_d  = 1'b0;
        s1_sticky_d = 1'b0;
        s1_big_d    = 1'b0;
        s1_nan_d    = 1'b0;
        if (in_exp == 8'd0) begin
            s1_sign_d = 1'b0;
        end else if (in_exp == 8'hFF) begin
            s1_nan_d = in_mant_nz;
            s1_big_d = !in_mant_nz;
        end else if (dec_e >= INT_W) begin
            s1_big_d = 1'b1;
        end else if (dec_e >= -32'sd1) begin
            s1_int_d    = dec_fixed[FW-1:25];
            s1_guard_d  = dec_fixed[24];
            s1_sticky_d = |dec_fixed[23:0];
        end else begin
            s1_sticky_d = 1'b1;
        end
    end

    // ---------------- stage 2: round and saturate ----------------
    logic             inc;
    logic [INT_W:0]   rnd_sum;
    logic             pos_ovf, neg_ovf, sat;
    logic             out_valid_q;
    logic [INT_W-1:0] out_data_q, out_data_d;

    always_comb begin
        inc = 1'b0;
        case (s1_rmode_q)
            2'd0:    inc = s1_guard_q;
            2'd1:    inc = 1'b0;
            2'd2:    inc = s1_sign_q & (s1_guard_q | s1_sticky_q);
            default: inc = !s1_sign_q & (s1_guard_q | s1_sticky_q);
        endcase
    end

    assign rnd_sum = {1'b0, s1_int_q} + {{INT_W{1'b0}}, inc};
    assign pos_ovf = !s1_sign_q && (rnd_sum > POS_LIM);
    assign neg_ovf = s1_sign_q && (rnd_sum > NEG_LIM);
    assign sat     = s1_big_q | pos_ovf | neg_ovf;

    always_comb begin
        out_data_d = '0;
        if (s1_nan_q)
            out_data_d = '0;
        else if (sat)
            out_data_d = s1_sign_q ? INT_MIN : INT_MAX;
        else if (s1_sign_q)
            out_data_d = '0 - rnd_sum[INT_W-1:0];
        else
            out_data_d = rnd_sum[INT_W-1:0];
    end

`ifdef FTOI_STATUS_EN
    logic out_ovf_q, out_ovf_d;
    logic out_inexact_q, out_inexact_d;
    assign out_ovf_d     = s1_nan_q | sat;
    assign out_inexact_d = (s1_guard_q | s1_sticky_q) & !out_ovf_d;
    assign out_ovf       = out_ovf_q;
    assign out_inexact   = out_inexact_q;
`endif

    // ---------------- flow control and state ----------------
    assign adv       = !out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_int_q      <= '0;
            s1_guard_q    <= 1'b0;
            s1_sticky_q   <= 1'b0;
            s1_big_q      <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_rmode_q    <= 2'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
`ifdef FTOI_STATUS_EN
            out_ovf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= s1_sign_d;
                s1_int_q    <= s1_int_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
                s1_big_q    <= s1_big_d;
                s1_nan_q    <= s1_nan_d;
                s1_rmode_q  <= in_rmode;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q    <= out_data_d;
`ifdef FTOI_STATUS_EN
                out_ovf_q     <= out_ovf_d;
                out_inexact_q <= out_inexact_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: a 32-bit and a 16-bit instance checked against hand-computed results.
module tb_ftoi_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [31:0] in_data_a = '0;
    logic [1:0]  in_rmode_a = '0;
    logic [31:0] out_data_a;

    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [31:0] in_data_b = '0;
    logic [1:0]  in_rmode_b = '0;
    logic [15:0] out_data_b;

`ifdef FTOI_STATUS_EN
    logic out_ovf_a, out_inexact_a, out_ovf_b, out_inexact_b;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  rm;
        logic [31:0] exp;
        logic        ovf;
        logic        inx;
    } vec_t;

    always #5 clk = ~clk;

    ftoi_pipe #(.INT_W(32)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_rmode(in_rmode_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a)
`ifdef FTOI_STATUS_EN
        , .out_ovf(out_ovf_a), .out_inexact(out_inexact_a)
`endif
    );

    ftoi_pipe #(.INT_W(16)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_rmode(in_rmode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
`ifdef FTOI_STATUS_EN
        , .out_ovf(out_ovf_b), .out_inexact(out_inexact_b)
`endif
    );

    // Drive one op into the selected instance and wait (bounded) for its result.
    task automatic op(input bit narrow, input logic [31:0] d, input logic [1:0] rm,
                      output logic [31:0] res, output logic ov, output logic inx, output int lat);
        logic vld;
        @(negedge clk);
        if (narrow) begin
            in_valid_b = 1'b1; in_data_b = d; in_rmode_b = rm; out_ready_b = 1'b1;
        end else begin
            in_valid_a = 1'b1; in_data_a = d; in_rmode_a = rm; out_ready_a = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            vld = narrow ? out_valid_b : out_valid_a;
        end while (!vld && lat < 8);
        if (!vld) lat = -1;
        res = narrow ? {16'd0, out_data_b} : out_data_a;
        ov  = 1'b0;
        inx = 1'b0;
`ifdef FTOI_STATUS_EN
        ov  = narrow ? out_ovf_b : out_ovf_a;
        inx = narrow ? out_inexact_b : out_inexact_a;
`endif
        $display("op w%0d in=%08h rm=%0d -> %08h ovf=%0b inx=%0b lat=%0d",
                 narrow ? 16 : 32, d, rm, res, ov, inx, lat);
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid_a !== 1'b0 || out_data_a !== 32'd0 || in_ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_a: got valid=%b data=%08h rdy=%b, want 0/00000000/1",
                     out_valid_a, out_data_a, in_ready_a);
        end
        n_vec++;
        if (out_valid_b !== 1'b0 || out_data_b !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_b: got valid=%b data=%04h, want 0/0000", out_valid_b, out_data_b);
        end
`ifdef FTOI_STATUS_EN
        n_vec++;
        if (out_ovf_a !== 1'b0 || out_inexact_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ovf=%b inx=%b, want 0/0", out_ovf_a, out_inexact_a);
        end
`endif
    endtask

    task automatic test_rounding();
        vec_t tv[$];
        logic [31:0] res;
        logic ov, inx;
        int lat;
        tv.push_back(vec_t'{32'h3FC00000, 2'd0, 32'h00000002, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3FC00000, 2'd1, 32'h00000001, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBFC00000, 2'd2, 32'hFFFFFFFE, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBFC00000, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h40200000, 2'd0, 32'h00000003, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hC0200000, 2'd1, 32'hFFFFFFFE, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBFA00000, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3F800000, 2'd2, 32'h00000001, 1'b0, 1'b0});
        foreach (tv[i]) begin
            op(1'b0, tv[i].d, tv[i].rm, res, ov, inx, lat);
            n_vec++;
            if (lat != 2 || res !== tv[i].exp) begin
                n_bad++;
                $display("FAIL round[%0d] in=%08h rm=%0d: got %08h lat=%0d, want %08h lat=2",
                         i, tv[i].d, tv[i].rm, res, lat, tv[i].exp);
            end
`ifdef FTOI_STATUS_EN
            n_vec++;
            if (ov !== tv[i].ovf || inx !== tv[i].inx) begin
                n_bad++;
                $display("FAIL round_flags[%0d]: got ovf=%b inx=%b, want ovf=%b inx=%b",
                         i, ov, inx, tv[i].ovf, tv[i].inx);
            end
`endif
        end
    endtask

    task automatic test_near_zero();
        vec_t tv[$];
        logic [31:0] res;
        logic ov, inx;
        int lat;
        tv.push_back(vec_t'{32'h3F000000, 2'd0, 32'h00000001, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBF000000, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h00400000, 2'd3, 32'h00000000, 1'b0, 1'b0});
        tv.push_back(vec_t'{32'h3E800000, 2'd3, 32'h00000001, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3E800000, 2'd0, 32'h00000000, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBE800000, 2'd3, 32'h00000000, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBE800000, 2'd2, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h80000000, 2'd2, 32'h00000000, 1'b0, 1'b0});
        foreach (tv[i]) begin
            op(1'b0, tv[i].d, tv[i].rm, res, ov, inx, lat);
            n_vec++;
            if (lat != 2 || res !== tv[i].exp) begin
                n_bad++;
                $display("FAIL zero[%0d] in=%08h rm=%0d: got %08h lat=%0d, want %08h lat=2",
                         i, tv[i].d, tv[i].rm, res, lat, tv[i].exp);
            end
`ifdef FTOI_STATUS_EN
            n_vec++;
            if (ov !== tv[i].ovf || inx !== tv[i].inx) begin
                n_bad++;
                $display("FAIL zero_flags[%0d]: got ovf=%b inx=%b, want ovf=%b inx=%b",
                         i, ov, inx, tv[i].ovf, tv[i].inx);
            end
`endif
        end
    endtask

    task automatic test_range();
        vec_t tv[$];
        logic [31:0] res;
        logic ov, inx;
        int lat;
        tv.push_back(vec_t'{32'h4F000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0});
        tv.push_back(vec_t'{32'h7FC00000, 2'd0, 32'h00000000, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'hFF800000, 2'd1, 32'h80000000, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'h7F800000, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'h4EFFFFFF, 2'd0, 32'h7FFFFF80, 1'b0, 1'b0});
        tv.push_back(vec_t'{32'h60000000, 2'd3, 32'h7FFFFFFF, 1'b1, 1'b0});
        foreach (tv[i]) begin
            op(1'b0, tv[i].d, tv[i].rm, res, ov, inx, lat);
            n_vec++;
            if (lat != 2 || res !== tv[i].exp) begin
                n_bad++;
                $display("FAIL range[%0d] in=%08h rm=%0d: got %08h lat=%0d, want %08h lat=2",
                         i, tv[i].d, tv[i].rm, res, lat, tv[i].exp);
            end
`ifdef FTOI_STATUS_EN
            n_vec++;
            if (ov !== tv[i].ovf || inx !== tv[i].inx) begin
                n_bad++;
                $display("FAIL range_flags[%0d]: got ovf=%b inx=%b, want ovf=%b inx=%b",
                         i, ov, inx, tv[i].ovf, tv[i].inx);
            end
`endif
        end
    endtask

    task automatic test_narrow();
        vec_t tv[$];
        logic [31:0] res;
        logic ov, inx;
        int lat;
        tv.push_back(vec_t'{32'h47000000, 2'd0, 32'h00007FFF, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'hC7000000, 2'd0, 32'h00008000, 1'b0, 1'b0});
        tv.push_back(vec_t'{32'h46FFFF00, 2'd0, 32'h00007FFF, 1'b1, 1'b0});
        tv.push_back(vec_t'{32'h46FFFF00, 2'd1, 32'h00007FFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3FC00000, 2'd0, 32'h00000002, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3FC00000, 2'd1, 32'h00000001, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBFC00000, 2'd2, 32'h0000FFFE, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBFC00000, 2'd3, 32'h0000FFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h3F000000, 2'd0, 32'h00000001, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'hBF000000, 2'd0, 32'h0000FFFF, 1'b0, 1'b1});
        tv.push_back(vec_t'{32'h00400000, 2'd0, 32'h00000000, 1'b0, 1'b0});
        tv.push_back(vec_t'{32'h3E800000, 2'd3, 32'h00000001, 1'b0, 1'b1});
        foreach (tv[i]) begin
            op(1'b1, tv[i].d, tv[i].rm, res, ov, inx, lat);
            n_vec++;
            if (lat != 2 || res !== tv[i].exp) begin
                n_bad++;
                $display("FAIL narrow[%0d] in=%08h rm=%0d: got %08h lat=%0d, want %08h lat=2",
                         i, tv[i].d, tv[i].rm, res, lat, tv[i].exp);
            end
`ifdef FTOI_STATUS_EN
            n_vec++;
            if (ov !== tv[i].ovf || inx !== tv[i].inx) begin
                n_bad++;
                $display("FAIL narrow_flags[%0d]: got ovf=%b inx=%b, want ovf=%b inx=%b",
                         i, ov, inx, tv[i].ovf, tv[i].inx);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vals[4];
        logic [31:0] got[$];
        logic [31:0] held;
        bit was_stalled;
        int idx;
        vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
        vals[2] = 32'h40400000; vals[3] = 32'h40800000;
        idx = 0;
        was_stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            @(negedge clk);
            out_ready_a = !(c >= 3 && c <= 5);
            #1;
            if (was_stalled && out_valid_a) begin
                n_vec++;
                if (out_data_a !== held) begin
                    n_bad++;
                    $display("FAIL bp_stable c=%0d: got %08h, want %08h", c, out_data_a, held);
                end
            end
            was_stalled = out_valid_a && !out_ready_a;
            held = out_data_a;
            if (was_stalled) begin
                n_vec++;
                if (in_ready_a !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready c=%0d: got %b, want 0", c, in_ready_a);
                end
            end
            if (out_valid_a && out_ready_a) begin
                got.push_back(out_data_a);
                $display("bp c=%0d out=%08h", c, out_data_a);
            end
            in_valid_a = (idx < 4);
            in_data_a  = vals[(idx < 4) ? idx : 3];
            in_rmode_a = 2'd1;
            if (in_valid_a && in_ready_a) idx++;
        end
        in_valid_a = 1'b0;
        n_vec++;
        if (got.size() != 4) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results, want 4", got.size());
        end
        foreach (got[i]) begin
            n_vec++;
            if (got[i] !== 32'(i + 1)) begin
                n_bad++;
                $display("FAIL bp_order[%0d]: got %08h, want %08h", i, got[i], 32'(i + 1));
            end
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_dup: got out_valid=%b after drain, want 0", out_valid_a);
        end
        out_ready_a = 1'b1;
    endtask

    task automatic test_reset_flight();
        logic [31:0] res;
        logic ov, inx;
        int lat;
        @(negedge clk);
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; in_data_a = 32'h40000000; in_rmode_a = 2'd0;
        @(negedge clk);
        in_data_a = 32'h40400000;
        @(negedge clk);
        in_data_a = 32'h40800000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid_a = 1'b0;
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_flight: got valid=%b rdy=%b data=%08h, want 0/1/00000000",
                     out_valid_a, in_ready_a, out_data_a);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stale: got out_valid=%b data=%08h, want 0", out_valid_a, out_data_a);
        end
        op(1'b0, 32'h40A00000, 2'd0, res, ov, inx, lat);
        n_vec++;
        if (lat != 2 || res !== 32'd5) begin
            n_bad++;
            $display("FAIL rst_after: got %08h lat=%0d, want 00000005 lat=2", res, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_rounding();
        test_near_zero();
        test_range();
        test_backpressure();
        test_reset_flight();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
